wb_stage: RTL and testbench

Write-back stage of the five-stage MIPS pipeline, directly downstream of `mem_stage`. It latches the memory-stage result bus and retires one instruction per handshake. Retirement drives the register-file write port with per-byte write enables, so LWL/LWR partial writes merge correctly. The stage also drives the forwarding and stall-detect buses back to decode, a debug trace port with back-pressure, and a retired-instruction counter.

---
 rtl/wb_stage.sv | 82 ++++++++
 tb/tb_wb_stage.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Write-back stage: holds one instruction from the memory stage, retires it into the
// register file with per-byte enables, and feeds forwarding, stall-detect and trace ports.
module wb_stage (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ms_to_ws_valid,
    input  logic [72:0] ms_to_ws_bus,
    output logic        ws_allowin,
    output logic [40:0] ws_to_rf_bus,
    output logic        ws_write_reg,
    output logic [4:0]  ws_reg_dest,
    output logic [35:0] ws_to_ds_bus,
    output logic        debug_wb_valid,
    input  logic        debug_wb_ready,
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_wen,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata,
    output logic [31:0] retire_cnt
);

    typedef struct packed {
        logic [3:0]  reg_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
    } ms_to_ws_t;

    logic        ws_valid;
    ms_to_ws_t   ms_to_ws_bus_r;
    logic [31:0] retire_cnt_q;

    logic        ws_ready_go;
    logic        retire;
    logic [3:0]  we_eff;
    logic [3:0]  rf_we;

    assign ws_ready_go = debug_wb_ready;
    assign ws_allowin  = !ws_valid || ws_ready_go;
    assign retire      = ws_valid && ws_ready_go;

    // Writes to $0 are dropped here so every consumer sees the same enables.
    assign we_eff = ms_to_ws_bus_r.reg_we & {4{ms_to_ws_bus_r.dest != 5'd0}};
    assign rf_we  = we_eff & {4{retire}};

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; the payload register is reset too, so stale fields read 0.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ws_valid       <= 1'b0;
            ms_to_ws_bus_r <= '0;
            retire_cnt_q   <= '0;
        end else begin
            if (ws_allowin) begin
                ws_valid <= ms_to_ws_valid;
            end
            if (ms_to_ws_valid && ws_allowin) begin
                ms_to_ws_bus_r <= ms_to_ws_t'(ms_to_ws_bus);
            end
            if (retire) begin
                retire_cnt_q <= retire_cnt_q + 32'd1;
            end
        end
    end

    assign ws_to_rf_bus = {rf_we, ms_to_ws_bus_r.dest, ms_to_ws_bus_r.final_result};

    assign ws_write_reg = ws_valid && (|we_eff);
    assign ws_reg_dest  = ms_to_ws_bus_r.dest;

    // Forward enables stay up for the whole stall, not just the retire cycle.
    assign ws_to_ds_bus = {ms_to_ws_bus_r.final_result, we_eff & {4{ws_valid}}};

    assign debug_wb_valid    = ws_valid;
    assign debug_wb_pc       = ms_to_ws_bus_r.pc;
    assign debug_wb_rf_wen   = we_eff;
    assign debug_wb_rf_wnum  = ms_to_ws_bus_r.dest;
    assign debug_wb_rf_wdata = ms_to_ws_bus_r.final_result;

    assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: a scoreboard tracks the held instruction, retire count and a
// byte-merging register file; a second register file is written from the DUT port.
module tb_wb_stage;

    typedef struct packed {
        logic [3:0]  reg_we;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] pc;
    } instr_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        ms_to_ws_valid = 1'b0;
    logic [72:0] ms_to_ws_bus = '0;
    logic        debug_wb_ready = 1'b0;
    logic        ws_allowin;
    logic [40:0] ws_to_rf_bus;
    logic        ws_write_reg;
    logic [4:0]  ws_reg_dest;
    logic [35:0] ws_to_ds_bus;
    logic        debug_wb_valid;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;
    logic [31:0] retire_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk               (clk),
        .resetn            (resetn),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .ws_allowin        (ws_allowin),
        .ws_to_rf_bus      (ws_to_rf_bus),
        .ws_write_reg      (ws_write_reg),
        .ws_reg_dest       (ws_reg_dest),
        .ws_to_ds_bus      (ws_to_ds_bus),
        .debug_wb_valid    (debug_wb_valid),
        .debug_wb_ready    (debug_wb_ready),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata),
        .retire_cnt        (retire_cnt)
    );

    // Register file driven by the DUT write port.
    bit [31:0] rf_dut [32];
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (ws_to_rf_bus[37+b]) begin
                rf_dut[ws_to_rf_bus[36:32]][b*8 +: 8] <= ws_to_rf_bus[b*8 +: 8];
            end
        end
    end

    // Scoreboard: held instruction, retirement count and expected register file.
    bit        m_valid;
    instr_t    m_last;
    logic [31:0] m_ret = '0;
    logic [31:0] cnt_base = '0;
    bit [31:0] rf_model [32];

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_valid = 1'b0;
            m_last  = '0;
            m_ret   = '0;
        end else begin
            if (m_valid && debug_wb_ready) begin
                m_ret = m_ret + 32'd1;
                if (m_last.dest != 5'd0) begin
                    for (int b = 0; b < 4; b++) begin
                        if (m_last.reg_we[b]) rf_model[m_last.dest][b*8 +: 8] = m_last.result[b*8 +: 8];
                    end
                end
            end
            if (!m_valid || debug_wb_ready) begin
                if (ms_to_ws_valid) m_last = instr_t'(ms_to_ws_bus);
                m_valid = ms_to_ws_valid;
            end
        end
    end

    wire [3:0]   x_we  = m_last.reg_we & {4{m_last.dest != 5'd0}};
    wire         x_ret = m_valid && debug_wb_ready;
    wire [189:0] exp_all = {!m_valid || debug_wb_ready,
                            x_we & {4{x_ret}}, m_last.dest, m_last.result,
                            m_valid && (x_we != 4'd0), m_last.dest,
                            m_last.result, x_we & {4{m_valid}},
                            m_valid, m_last.pc, x_we, m_last.dest, m_last.result,
                            cnt_base + m_ret};
    wire [189:0] obs_all = {ws_allowin, ws_to_rf_bus, ws_write_reg, ws_reg_dest, ws_to_ds_bus,
                            debug_wb_valid, debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum,
                            debug_wb_rf_wdata, retire_cnt};

    function automatic logic [72:0] mk(input logic [3:0] we, input logic [4:0] dest,
                                       input logic [31:0] res, input logic [31:0] pc);
        return {we, dest, res, pc};
    endfunction

    task automatic step(input bit v, input logic [72:0] b, input bit r);
        @(negedge clk);
        ms_to_ws_valid = v;
        ms_to_ws_bus   = b;
        debug_wb_ready = r;
        #1;
    endtask

    task automatic test_reset;
        #2;
        n_checks++;
        if (obs_all !== {1'b1, 189'd0}) begin
            n_fail++; $display("FAIL reset_init: got %h expected %h", obs_all, {1'b1, 189'd0});
        end
        @(negedge clk);
        resetn = 1'b1;
        step(1'b1, mk(4'hF, 5'd5, 32'hDEAD_BEEF, 32'hBFC0_0000), 1'b0);
        step(1'b0, '0, 1'b0);
        n_checks++;
        if (debug_wb_valid !== 1'b1) begin
            n_fail++; $display("FAIL reset_held: valid got %b expected 1", debug_wb_valid);
        end
        #2 resetn = 1'b0;
        #1;
        n_checks++;
        if (obs_all !== {1'b1, 189'd0}) begin
            n_fail++; $display("FAIL reset_async: got %h expected %h", obs_all, {1'b1, 189'd0});
        end
        @(negedge clk);
        resetn = 1'b1;
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        n_checks++;
        if (rf_dut[5] !== 32'd0 || retire_cnt !== 32'd0) begin
            n_fail++; $display("FAIL reset_discard: rf5 %h cnt %h expected 0 0", rf_dut[5], retire_cnt);
        end
    endtask

    task automatic test_word_load;
        step(1'b1, mk(4'hF, 5'd8, 32'h1234_5678, 32'hBFC0_0100), 1'b1);
        n_checks++;
        if (obs_all !== exp_all) begin
            n_fail++; $display("FAIL word_present: got %h expected %h", obs_all, exp_all);
        end
        step(1'b0, '0, 1'b1);
        n_checks++;
        if (ws_to_rf_bus !== {4'hF, 5'd8, 32'h1234_5678} || debug_wb_pc !== 32'hBFC0_0100
            || retire_cnt !== 32'd0) begin
            n_fail++; $display("FAIL word_retire: rf %h pc %h cnt %h expected %h bfc00100 0",
                               ws_to_rf_bus, debug_wb_pc, retire_cnt, {4'hF, 5'd8, 32'h1234_5678});
        end
        step(1'b0, '0, 1'b1);
        n_checks++;
        if (retire_cnt !== 32'd1 || rf_dut[8] !== 32'h1234_5678) begin
            n_fail++; $display("FAIL word_after: cnt %h rf8 %h expected 1 12345678", retire_cnt, rf_dut[8]);
        end
    endtask

    task automatic test_lwl;
        logic [31:0] full = $urandom;
        logic [15:0] lo   = 16'($urandom);
        step(1'b1, mk(4'hF, 5'd9, full, 32'hBFC0_0200), 1'b1);
        step(1'b1, mk(4'b1100, 5'd9, {16'hAABB, lo}, 32'hBFC0_0204), 1'b1);
        n_checks++;
        if (obs_all !== exp_all) begin
            n_fail++; $display("FAIL lwl_first: got %h expected %h", obs_all, exp_all);
        end
        step(1'b0, '0, 1'b1);
        n_checks++;
        if (ws_to_rf_bus[40:37] !== 4'b1100 || ws_to_ds_bus[3:0] !== 4'b1100) begin
            n_fail++; $display("FAIL lwl_enables: rf_we %b fwd %b expected 1100 1100",
                               ws_to_rf_bus[40:37], ws_to_ds_bus[3:0]);
        end
        step(1'b0, '0, 1'b1);
        n_checks++;
        if (rf_dut[9] !== {16'hAABB, full[15:0]} || rf_model[9] !== rf_dut[9]) begin
            n_fail++; $display("FAIL lwl_merge: rf9 %h expected %h", rf_dut[9], {16'hAABB, full[15:0]});
        end
    endtask

    task automatic test_zero_dest;
        logic [31:0] c;
        step(1'b1, mk(4'hF, 5'd0, $urandom, 32'hBFC0_0300), 1'b1);
        step(1'b0, '0, 1'b1);
        c = retire_cnt;
        n_checks++;
        if (ws_to_rf_bus[40:37] !== 4'd0 || ws_write_reg !== 1'b0 || debug_wb_rf_wen !== 4'd0
            || debug_wb_valid !== 1'b1) begin
            n_fail++; $display("FAIL zero_suppress: rf_we %b wr %b wen %b vld %b expected 0 0 0 1",
                               ws_to_rf_bus[40:37], ws_write_reg, debug_wb_rf_wen, debug_wb_valid);
        end
        step(1'b0, '0, 1'b1);
        n_checks++;
        if (retire_cnt !== c + 32'd1) begin
            n_fail++; $display("FAIL zero_count: got %h expected %h", retire_cnt, c + 32'd1);
        end
    endtask

    task automatic test_back_pressure;
        logic [31:0]  c;
        logic [72:0]  a_bus = mk(4'b0011, 5'd12, $urandom, 32'hBFC0_0400);
        logic [72:0]  b_bus = mk(4'hF, 5'd13, $urandom, 32'hBFC0_0404);
        logic [72:0]  snap;
        step(1'b1, a_bus, 1'b1);
        step(1'b1, b_bus, 1'b0);
        c    = retire_cnt;
        snap = {debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata};
        for (int i = 0; i < 3; i++) begin
            if (i != 0) step(1'b1, b_bus, 1'b0);
            n_checks++;
            if (ws_allowin !== 1'b0 || ws_to_rf_bus[40:37] !== 4'd0 || retire_cnt !== c
                || {debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata} !== snap
                || snap !== {32'hBFC0_0400, 4'b0011, 5'd12, a_bus[63:32]}) begin
                n_fail++; $display("FAIL stall_cycle%0d: allowin %b rf_we %b trace %h expected 0 0 %h",
                                   i, ws_allowin, ws_to_rf_bus[40:37],
                                   {debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata},
                                   {32'hBFC0_0400, 4'b0011, 5'd12, a_bus[63:32]});
            end
        end
        step(1'b1, b_bus, 1'b1);
        n_checks++;
        if (ws_allowin !== 1'b1 || ws_to_rf_bus[40:37] !== 4'b0011 || obs_all !== exp_all) begin
            n_fail++; $display("FAIL stall_release: got %h expected %h", obs_all, exp_all);
        end
        step(1'b0, '0, 1'b1);
        n_checks++;
        if (debug_wb_pc !== 32'hBFC0_0404 || retire_cnt !== c + 32'd1 || rf_dut[12] !== rf_model[12]) begin
            n_fail++; $display("FAIL stall_next: pc %h cnt %h expected bfc00404 %h", debug_wb_pc,
                               retire_cnt, c + 32'd1);
        end
    endtask

    task automatic test_wrap_stream;
        logic [31:0] exp_seq [3] = '{32'hFFFF_FFFF, 32'h0, 32'h1};
        step(1'b0, '0, 1'b0);
        force dut.retire_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.retire_cnt_q;
        cnt_base = 32'hFFFF_FFFE - m_ret;
        step(1'b1, mk(4'hF, 5'd20, $urandom, 32'hBFC0_1000), 1'b1);
        step(1'b1, mk(4'hF, 5'd21, $urandom, 32'hBFC0_1004), 1'b1);
        n_checks++;
        if (retire_cnt !== 32'hFFFF_FFFE || debug_wb_valid !== 1'b1) begin
            n_fail++; $display("FAIL wrap_start: cnt %h vld %b expected fffffffe 1", retire_cnt, debug_wb_valid);
        end
        for (int i = 0; i < 3; i++) begin
            if (i == 0) step(1'b1, mk(4'hF, 5'd22, $urandom, 32'hBFC0_1008), 1'b1);
            else        step(1'b0, '0, 1'b1);
            n_checks++;
            if (retire_cnt !== exp_seq[i] || debug_wb_valid !== (i < 2)
                || (i < 2 && debug_wb_pc !== 32'hBFC0_1004 + 32'(4 * i))) begin
                n_fail++; $display("FAIL wrap_seq%0d: cnt %h vld %b pc %h expected %h %b", i,
                                   retire_cnt, debug_wb_valid, debug_wb_pc, exp_seq[i], i < 2);
            end
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 9) < 7,
                 mk(4'($urandom), 5'($urandom_range(0, 3)), $urandom, $urandom),
                 $urandom_range(0, 9) < 7);
            n_checks++;
            if (obs_all !== exp_all) begin
                n_fail++; $display("FAIL random_cycle%0d: got %h expected %h", i, obs_all, exp_all);
            end
        end
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        for (int r = 0; r < 32; r++) begin
            n_checks++;
            if (rf_dut[r] !== rf_model[r]) begin
                n_fail++; $display("FAIL random_rf%0d: got %h expected %h", r, rf_dut[r], rf_model[r]);
            end
        end
    endtask

    initial begin
        test_reset;
        test_word_load;
        test_lwl;
        test_zero_dest;
        test_back_pressure;
        test_random;
        test_wrap_stream;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
